// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory arbiter slice.
// Holds default bus widths, the 2-bit arbiter state encoding and the
// SRAM control bundle with its idle (all deasserted) value.
package mips_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 7;
    localparam int unsigned DATA_W_DEF = 32;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CORE_RD = 2'd1;
    localparam logic [1:0] ST_DBG_RD  = 2'd2;

    // Active-low SRAM strobes, kept together so they move as one unit
    typedef struct packed {
        logic cen;
        logic wen;
        logic oen;
    } mem_ctrl_t;

    localparam mem_ctrl_t MEM_CTRL_IDLE = 3'b111;

endpackage

// File: rtl/mips_arb_starve_ctr.sv
// Saturating starvation counter for the data-memory arbiter.
// Counts consecutive core grants taken while debug is waiting.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   clr         - return count to zero (takes priority over inc)
//   inc         - count one more core grant, saturating at STARVE_MAX
//   at_limit    - count has reached STARVE_MAX; debug must be served next
module mips_arb_starve_ctr #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] cnt_q;

    assign at_limit = (cnt_q >= CNT_W'(STARVE_MAX));

    // Saturating count register
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt_q <= '0;
        end else if (inc && !at_limit) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mips_dmem_arbiter.sv
// Shares the single-port data SRAM between the single-cycle MIPS core and a
// debug/loader port. The core has fixed priority; core loads take one stall
// cycle to collect the 1-cycle-latency SRAM data. A starvation counter forces
// a debug grant after STARVE_MAX core grants taken while debug waits.
// Ports:
//   clk, rst_n                     - clock, synchronous active-low reset
//   core_cen/wen/oen/a/wdata       - core data port (active-low strobes)
//   core_rdata, core_stall         - load data and PC/regfile hold to the core
//   dbg_req/we/a/wdata             - debug request, held until dbg_gnt
//   dbg_gnt, dbg_rvalid, dbg_rdata - debug grant and read return
//   mem_cen/wen/oen/a/wdata        - SRAM macro controls (combinational)
//   mem_rdata                      - SRAM read data, one cycle after issue
module mips_dmem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_cen,
    input  logic              core_wen,
    input  logic              core_oen,
    input  logic [ADDR_W-1:0] core_a,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_a,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_cen,
    output logic              mem_wen,
    output logic              mem_oen,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0] state_q;
    logic [1:0] state_d;
    mem_ctrl_t  mem_ctrl;
    logic       core_wr;
    logic       core_rd;
    logic       core_req;
    logic       core_win;
    logic       dbg_win;
    logic       cnt_clr;
    logic       cnt_inc;
    logic       cnt_at_limit;

    // Decode core request; a store wins when both strobes are low
    assign core_wr  = ~core_cen & ~core_wen;
    assign core_rd  = ~core_cen &  core_wen & ~core_oen;
    assign core_req = core_wr | core_rd;

    // Fixed core priority unless debug has been starved to the limit
    assign core_win = core_req & (~dbg_req | ~cnt_at_limit);
    assign dbg_win  = dbg_req & ~core_win;

    assign mem_cen = mem_ctrl.cen;
    assign mem_wen = mem_ctrl.wen;
    assign mem_oen = mem_ctrl.oen;

    mips_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .at_limit (cnt_at_limit)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: both read-return states last exactly one cycle
    always_comb begin
        state_d = ST_IDLE;
        if (state_q == ST_IDLE) begin
            if (core_win && core_rd) begin
                state_d = ST_CORE_RD;
            end else if (dbg_win && !dbg_we) begin
                state_d = ST_DBG_RD;
            end
        end
    end

    // Outputs: SRAM mux, stall/grant, read return; all held idle in reset
    always_comb begin
        mem_ctrl   = MEM_CTRL_IDLE;
        mem_a      = '0;
        mem_wdata  = '0;
        core_rdata = '0;
        core_stall = 1'b0;
        dbg_gnt    = 1'b0;
        dbg_rvalid = 1'b0;
        dbg_rdata  = '0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_IDLE: begin
                    if (core_win) begin
                        mem_ctrl   = '{cen: 1'b0, wen: ~core_wr, oen: ~core_rd};
                        mem_a      = core_a;
                        mem_wdata  = core_wr ? core_wdata : '0;
                        core_stall = core_rd;
                        cnt_inc    = dbg_req;
                        cnt_clr    = ~dbg_req;
                    end else if (dbg_win) begin
                        mem_ctrl   = '{cen: 1'b0, wen: ~dbg_we, oen: dbg_we};
                        mem_a      = dbg_a;
                        mem_wdata  = dbg_we ? dbg_wdata : '0;
                        dbg_gnt    = 1'b1;
                        core_stall = core_req;
                        cnt_clr    = 1'b1;
                    end else begin
                        cnt_clr    = 1'b1;
                    end
                end
                // Core load completes; the still-present lw is not re-issued
                ST_CORE_RD: begin
                    core_rdata = mem_rdata;
                end
                ST_DBG_RD: begin
                    dbg_rvalid = 1'b1;
                    dbg_rdata  = mem_rdata;
                    core_stall = core_req;
                end
                default: ;
            endcase
        end
    end

endmodule
